// File: rtl/mask_unit_xbar_pkg.sv
// Shared types and helpers for the mask-unit read crossbar.
// The struct types describe one request/response at the default field widths.
package mask_unit_xbar_pkg;

  localparam int VS_W_DEF     = 5;
  localparam int OFFSET_W_DEF = 3;
  localparam int DOFF_W_DEF   = 2;
  localparam int LANE_W_DEF   = 2;
  localparam int IDX_W_DEF    = 2;

  typedef struct packed {
    logic [VS_W_DEF-1:0]     vs;
    logic [OFFSET_W_DEF-1:0] offset;
    logic [LANE_W_DEF-1:0]   readLane;
    logic [DOFF_W_DEF-1:0]   dataOffset;
  } read_req_t;

  typedef struct packed {
    logic [VS_W_DEF-1:0]     vs;
    logic [OFFSET_W_DEF-1:0] offset;
    logic [IDX_W_DEF-1:0]    writeIndex;
    logic [DOFF_W_DEF-1:0]   dataOffset;
  } read_out_t;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer moves to the requester just after the winner, wrapping at num.
  function automatic int rr_next(input int idx, input int num);
    return (idx + 1 >= num) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mask_unit_rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr (mod NUM_INPUT) wins.
// Purely combinational; the owner updates the pointer.
module mask_unit_rr_arbiter
  import mask_unit_xbar_pkg::*;
#(
  parameter int  NUM_INPUT = 4,
  localparam int IDX_W     = clog2_min1(NUM_INPUT)
) (
  input  logic [NUM_INPUT-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_INPUT-1:0] grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic                 any
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    for (int k = 0; k < NUM_INPUT; k++) begin
      idx = (int'(ptr) + k) % NUM_INPUT;
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/mask_unit_read_xbar_rr.sv
// Read crossbar: routes requesters to lanes by readLane with per-lane round-robin
// and a registered 1-entry output slot per lane. Optional MASK_UNIT_READ_XBAR_PERF_EN.
module mask_unit_read_xbar_rr
  import mask_unit_xbar_pkg::*;
#(
  parameter int  NUM_INPUT = 4,
  parameter int  NUM_LANE  = 4,
  parameter int  VS_W      = 5,
  parameter int  OFFSET_W  = 3,
  parameter int  DOFF_W    = 2,
  localparam int LANE_W    = clog2_min1(NUM_LANE),
  localparam int IDX_W     = clog2_min1(NUM_INPUT)
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_INPUT-1:0]          input_valid,
  output logic [NUM_INPUT-1:0]          input_ready,
  input  logic [NUM_INPUT*VS_W-1:0]     input_bits_vs,
  input  logic [NUM_INPUT*OFFSET_W-1:0] input_bits_offset,
  input  logic [NUM_INPUT*LANE_W-1:0]   input_bits_readLane,
  input  logic [NUM_INPUT*DOFF_W-1:0]   input_bits_dataOffset,
  output logic [NUM_LANE-1:0]           output_valid,
  input  logic [NUM_LANE-1:0]           output_ready,
  output logic [NUM_LANE*VS_W-1:0]      output_bits_vs,
  output logic [NUM_LANE*OFFSET_W-1:0]  output_bits_offset,
  output logic [NUM_LANE*IDX_W-1:0]     output_bits_writeIndex,
  output logic [NUM_LANE*DOFF_W-1:0]    output_bits_dataOffset
`ifdef MASK_UNIT_READ_XBAR_PERF_EN
  ,
  output logic [31:0]                   conflict_count
`endif
);

  logic [VS_W-1:0]     in_vs   [NUM_INPUT];
  logic [OFFSET_W-1:0] in_off  [NUM_INPUT];
  logic [LANE_W-1:0]   in_lane [NUM_INPUT];
  logic [DOFF_W-1:0]   in_doff [NUM_INPUT];

  logic [NUM_INPUT-1:0] req       [NUM_LANE];
  logic [NUM_INPUT-1:0] grant     [NUM_LANE];
  logic [IDX_W-1:0]     grant_idx [NUM_LANE];
  logic [NUM_LANE-1:0]  grant_any;
  logic [NUM_LANE-1:0]  can_accept;
  logic [NUM_LANE-1:0]  fire;

  logic [IDX_W-1:0]    ptr    [NUM_LANE];
  logic [NUM_LANE-1:0] s_valid;
  logic [VS_W-1:0]     s_vs   [NUM_LANE];
  logic [OFFSET_W-1:0] s_off  [NUM_LANE];
  logic [IDX_W-1:0]    s_widx [NUM_LANE];
  logic [DOFF_W-1:0]   s_doff [NUM_LANE];

  genvar gi, gl;
  generate
    for (gi = 0; gi < NUM_INPUT; gi++) begin : g_unpack
      assign in_vs[gi]   = input_bits_vs[gi*VS_W +: VS_W];
      assign in_off[gi]  = input_bits_offset[gi*OFFSET_W +: OFFSET_W];
      assign in_lane[gi] = input_bits_readLane[gi*LANE_W +: LANE_W];
      assign in_doff[gi] = input_bits_dataOffset[gi*DOFF_W +: DOFF_W];
    end

    for (gl = 0; gl < NUM_LANE; gl++) begin : g_lane
      mask_unit_rr_arbiter #(.NUM_INPUT(NUM_INPUT)) u_arb (
        .req       (req[gl]),
        .ptr       (ptr[gl]),
        .grant     (grant[gl]),
        .grant_idx (grant_idx[gl]),
        .any       (grant_any[gl])
      );
      assign output_bits_vs[gl*VS_W +: VS_W]             = s_vs[gl];
      assign output_bits_offset[gl*OFFSET_W +: OFFSET_W] = s_off[gl];
      assign output_bits_writeIndex[gl*IDX_W +: IDX_W]   = s_widx[gl];
      assign output_bits_dataOffset[gl*DOFF_W +: DOFF_W] = s_doff[gl];
    end
  endgenerate

  assign output_valid = s_valid;

  // Out-of-range readLane values match no lane, so they are never granted.
  always_comb begin
    for (int l = 0; l < NUM_LANE; l++) begin
      for (int i = 0; i < NUM_INPUT; i++) begin
        req[l][i] = input_valid[i] && (in_lane[i] == LANE_W'(l));
      end
    end
  end

  assign can_accept = ~s_valid | output_ready;
  assign fire       = grant_any & can_accept & {NUM_LANE{~reset}};

  always_comb begin
    input_ready = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      for (int l = 0; l < NUM_LANE; l++) begin
        input_ready[i] = input_ready[i] | (grant[l][i] & fire[l]);
      end
    end
  end

  // A fire on a lane overwrites the slot even if it is being dequeued this cycle.
  always_ff @(posedge clock) begin
    for (int l = 0; l < NUM_LANE; l++) begin
      if (reset) begin
        s_valid[l] <= 1'b0;
        ptr[l]     <= '0;
        s_vs[l]    <= '0;
        s_off[l]   <= '0;
        s_widx[l]  <= '0;
        s_doff[l]  <= '0;
      end else if (fire[l]) begin
        s_valid[l] <= 1'b1;
        ptr[l]     <= IDX_W'(rr_next(int'(grant_idx[l]), NUM_INPUT));
        s_vs[l]    <= in_vs[grant_idx[l]];
        s_off[l]   <= in_off[grant_idx[l]];
        s_widx[l]  <= grant_idx[l];
        s_doff[l]  <= in_doff[grant_idx[l]];
      end else if (output_ready[l]) begin
        s_valid[l] <= 1'b0;
      end
    end
  end

`ifdef MASK_UNIT_READ_XBAR_PERF_EN
  logic [IDX_W:0] n_conflict;
  logic [32:0]    cc_sum;

  // Losers of arbitration or slot backpressure; out-of-range requests are not conflicts.
  always_comb begin
    n_conflict = '0;
    for (int i = 0; i < NUM_INPUT; i++) begin
      if (input_valid[i] && (int'(in_lane[i]) < NUM_LANE) && !input_ready[i]) begin
        n_conflict = n_conflict + (IDX_W+1)'(1);
      end
    end
  end

  assign cc_sum = {1'b0, conflict_count} + 33'(n_conflict);

  always_ff @(posedge clock) begin
    if (reset) begin
      conflict_count <= '0;
    end else begin
      conflict_count <= cc_sum[32] ? 32'hFFFF_FFFF : cc_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_mask_unit_read_xbar_rr.sv
// Bench for mask_unit_read_xbar_rr: cycle vectors with per-lane expected-output queues,
// plus an out-of-range readLane sequence on a 3-lane instance.
module tb_mask_unit_read_xbar_rr;
  import mask_unit_xbar_pkg::*;

  localparam int NI  = 4;
  localparam int NL  = 4;
  localparam int NL3 = 3;
  localparam int NV  = 22;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [NI-1:0]   input_valid, input_ready;
  logic [NI*5-1:0] in_vs;
  logic [NI*3-1:0] in_off;
  logic [NI*2-1:0] in_lane, in_doff;
  logic [NL-1:0]   out_valid, out_ready;
  logic [NL*5-1:0] out_vs;
  logic [NL*3-1:0] out_off;
  logic [NL*2-1:0] out_widx, out_doff;

  logic [NI-1:0]    v3, r3;
  logic [NI*2-1:0]  lane3;
  logic [NL3-1:0]   o3_valid, o3_ready;
  logic [NL3*5-1:0] o3_vs;
  logic [NL3*3-1:0] o3_off;
  logic [NL3*2-1:0] o3_widx, o3_doff;

`ifdef MASK_UNIT_READ_XBAR_PERF_EN
  logic [31:0] cc, cc3;
`endif

  mask_unit_read_xbar_rr #(.NUM_INPUT(NI), .NUM_LANE(NL)) u_dut (
    .clock(clock), .reset(reset),
    .input_valid(input_valid), .input_ready(input_ready),
    .input_bits_vs(in_vs), .input_bits_offset(in_off),
    .input_bits_readLane(in_lane), .input_bits_dataOffset(in_doff),
    .output_valid(out_valid), .output_ready(out_ready),
    .output_bits_vs(out_vs), .output_bits_offset(out_off),
    .output_bits_writeIndex(out_widx), .output_bits_dataOffset(out_doff)
`ifdef MASK_UNIT_READ_XBAR_PERF_EN
    , .conflict_count(cc)
`endif
  );

  mask_unit_read_xbar_rr #(.NUM_INPUT(NI), .NUM_LANE(NL3)) u_dut3 (
    .clock(clock), .reset(reset),
    .input_valid(v3), .input_ready(r3),
    .input_bits_vs(in_vs), .input_bits_offset(in_off),
    .input_bits_readLane(lane3), .input_bits_dataOffset(in_doff),
    .output_valid(o3_valid), .output_ready(o3_ready),
    .output_bits_vs(o3_vs), .output_bits_offset(o3_off),
    .output_bits_writeIndex(o3_widx), .output_bits_dataOffset(o3_doff)
`ifdef MASK_UNIT_READ_XBAR_PERF_EN
    , .conflict_count(cc3)
`endif
  );

  typedef struct {
    logic       rst;
    logic [3:0] v;
    logic [7:0] l;
    logic [3:0] o;
    logic [3:0] e;
  } vec_t;

  vec_t      vecs [NV];
  read_req_t reqs [NI];
  read_out_t sbq  [NL][$];
  int        checks = 0;
  int        errors = 0;
  int        cc_exp = 0;

  function automatic vec_t mk(input logic rst, input logic [3:0] v, input logic [7:0] l,
                              input logic [3:0] o, input logic [3:0] e);
    vec_t t;
    t.rst = rst; t.v = v; t.l = l; t.o = o; t.e = e;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Payload depends on row and requester so every slot entry is distinguishable.
  task automatic drive_reqs(input int row, input logic [7:0] lanes);
    for (int i = 0; i < NI; i++) begin
      reqs[i].vs         = 5'(row * 3 + i + 1);
      reqs[i].offset     = 3'(row + i);
      reqs[i].readLane   = lanes[2*i +: 2];
      reqs[i].dataOffset = 2'(i);
      in_vs[i*5 +: 5]    = reqs[i].vs;
      in_off[i*3 +: 3]   = reqs[i].offset;
      in_lane[i*2 +: 2]  = reqs[i].readLane;
      in_doff[i*2 +: 2]  = reqs[i].dataOffset;
    end
  endtask

  initial begin
    // idle after reset
    vecs[0]  = mk(0, 4'h0, 8'h00, 4'h0, 4'h0);
    vecs[1]  = mk(0, 4'h0, 8'h00, 4'h0, 4'h0);
    vecs[2]  = mk(0, 4'h0, 8'h00, 4'h0, 4'h0);
    // all four on lane 2: rotation 0,1,2,3
    vecs[3]  = mk(0, 4'hF, 8'hAA, 4'hF, 4'h1);
    vecs[4]  = mk(0, 4'hF, 8'hAA, 4'hF, 4'h2);
    vecs[5]  = mk(0, 4'hF, 8'hAA, 4'hF, 4'h4);
    vecs[6]  = mk(0, 4'hF, 8'hAA, 4'hF, 4'h8);
    vecs[7]  = mk(0, 4'h0, 8'h00, 4'hF, 4'h0);
    // parallel routing: input i -> lane 3-i
    vecs[8]  = mk(0, 4'hF, 8'h1B, 4'hF, 4'hF);
    vecs[9]  = mk(0, 4'h0, 8'h00, 4'hF, 4'h0);
    // backpressure on lane 0, then dequeue+enqueue in one cycle
    vecs[10] = mk(0, 4'h2, 8'h00, 4'h0, 4'h2);
    vecs[11] = mk(0, 4'h4, 8'h00, 4'h0, 4'h0);
    vecs[12] = mk(0, 4'h4, 8'h00, 4'h0, 4'h0);
    vecs[13] = mk(0, 4'h4, 8'h00, 4'h0, 4'h0);
    vecs[14] = mk(0, 4'h4, 8'h00, 4'h1, 4'h4);
    vecs[15] = mk(0, 4'h0, 8'h00, 4'hF, 4'h0);
    // reset mid-operation with lane 1 occupied and ptr[1]=1
    vecs[16] = mk(0, 4'h1, 8'h01, 4'h0, 4'h1);
    vecs[17] = mk(0, 4'h0, 8'h00, 4'h0, 4'h0);
    vecs[18] = mk(1, 4'h1, 8'h01, 4'h0, 4'h0);
    vecs[19] = mk(0, 4'h3, 8'h05, 4'h0, 4'h1);
    vecs[20] = mk(0, 4'h0, 8'h00, 4'hF, 4'h0);
    vecs[21] = mk(0, 4'h0, 8'h00, 4'hF, 4'h0);

    reset = 1'b1;
    input_valid = 4'h1;
    out_ready = '0;
    v3 = '0;
    lane3 = '0;
    o3_ready = '0;
    drive_reqs(0, 8'h00);
    @(negedge clock);
    #1;
    chk("reset_ready", 64'(input_ready), 64'h0);
    chk("reset_valid", 64'(out_valid), 64'h0);
    chk("reset_valid3", 64'(o3_valid), 64'h0);

    for (int r = 0; r < NV; r++) begin
      @(negedge clock);
      reset       = vecs[r].rst;
      input_valid = vecs[r].v;
      out_ready   = vecs[r].o;
      drive_reqs(r, vecs[r].l);
      #1;
      chk($sformatf("ready_r%0d", r), 64'(input_ready), 64'(vecs[r].e));
      for (int l = 0; l < NL; l++) begin
        if (sbq[l].size() > 0) begin
          chk($sformatf("lane%0d_r%0d", l, r),
              64'({out_valid[l], out_vs[l*5 +: 5], out_off[l*3 +: 3],
                   out_widx[l*2 +: 2], out_doff[l*2 +: 2]}),
              64'({1'b1, sbq[l][0]}));
          if (vecs[r].o[l]) void'(sbq[l].pop_front());
        end else begin
          chk($sformatf("lane%0d_idle_r%0d", l, r), 64'(out_valid[l]), 64'h0);
        end
      end
`ifdef MASK_UNIT_READ_XBAR_PERF_EN
      chk($sformatf("conflict_r%0d", r), 64'(cc), 64'(cc_exp));
`endif
      if (vecs[r].rst) begin
        for (int l = 0; l < NL; l++) sbq[l].delete();
        cc_exp = 0;
      end else begin
        for (int i = 0; i < NI; i++) begin
          if (vecs[r].v[i] && vecs[r].e[i]) begin
            read_out_t t;
            t.vs         = reqs[i].vs;
            t.offset     = reqs[i].offset;
            t.writeIndex = 2'(i);
            t.dataOffset = reqs[i].dataOffset;
            sbq[reqs[i].readLane].push_back(t);
          end else if (vecs[r].v[i]) begin
            cc_exp++;
          end
        end
      end
    end

    // 3-lane instance: readLane=3 is never served; input 1 on lane 0 flows normally.
    input_valid = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      v3       = 4'b0011;
      lane3    = 8'b00_00_00_11;
      o3_ready = 3'b111;
      #1;
      chk($sformatf("oor_ready_c%0d", c), 64'(r3), 64'h2);
      chk($sformatf("oor_valid_c%0d", c), 64'(o3_valid), (c == 0) ? 64'h0 : 64'h1);
      if (c > 0) chk($sformatf("oor_widx_c%0d", c), 64'(o3_widx[1:0]), 64'h1);
    end
    v3 = '0;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
